debug_step_ctrl: RTL

DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

---
 rtl/debug_step_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/debug_step_ctrl.sv
// Debug step controller: takes single-byte host commands (run, step, print),
// gates the pipeline advance-enable, then captures the program counter and
// streams it back to the host MSB first over a valid/ready byte channel.
module debug_step_ctrl #(
   parameter int unsigned SIZE_ADDR_PC = 32,
   parameter int unsigned SIZE_BYTE    = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [SIZE_BYTE-1:0]    i_cmd_data,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic [SIZE_ADDR_PC-1:0] i_pc,
   input  logic                    i_halt,
   output logic                    o_step,
   output logic [SIZE_BYTE-1:0]    o_tx_data,
   output logic                    o_tx_valid,
   input  logic                    i_tx_ready,
   output logic                    o_busy
);

   localparam logic [SIZE_BYTE-1:0] CMD_RUN   = SIZE_BYTE'(8'h63);
   localparam logic [SIZE_BYTE-1:0] CMD_STEP  = SIZE_BYTE'(8'h73);
   localparam logic [SIZE_BYTE-1:0] CMD_PRINT = SIZE_BYTE'(8'h70);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      STEP,
      CAPTURE,
      SEND
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [SIZE_ADDR_PC-1:0] pc_latch_q, pc_latch_d;
   logic [1:0]              byte_sel;
   logic [SIZE_ADDR_PC-1:0] pc_shift;

   // State, byte counter and captured PC; reset clears everything at once so
   // the state-decoded outputs drop without waiting for a clock edge.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pc_latch_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_latch_q <= pc_latch_d;
      end
   end

   // Next-state and output decode; i_halt is only looked at while running.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_latch_d  = pc_latch_q;
      o_cmd_ready = 1'b0;
      o_step      = 1'b0;
      o_tx_valid  = 1'b0;
      o_tx_data   = '0;
      o_busy      = 1'b1;
      byte_sel    = 2'd3 - cnt_q;
      pc_shift    = pc_latch_q >> (SIZE_BYTE * 32'(byte_sel));

      case (state_q)
         IDLE: begin
            o_cmd_ready = 1'b1;
            o_busy      = 1'b0;
            if (i_cmd_valid) begin
               if (i_cmd_data == CMD_RUN) begin
                  state_d = RUN;
               end else if (i_cmd_data == CMD_STEP) begin
                  state_d = STEP;
               end else if (i_cmd_data == CMD_PRINT) begin
                  state_d = CAPTURE;
               end
            end
         end
         RUN: begin
            if (i_halt) begin
               state_d = CAPTURE;
            end else begin
               o_step = 1'b1;
            end
         end
         STEP: begin
            o_step  = 1'b1;
            state_d = CAPTURE;
         end
         CAPTURE: begin
            pc_latch_d = i_pc;
            cnt_d      = '0;
            state_d    = SEND;
         end
         SEND: begin
            o_tx_valid = 1'b1;
            o_tx_data  = pc_shift[SIZE_BYTE-1:0];
            if (i_tx_ready) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
